fc_result_reader: RTL and testbench
===================================

// Module: fc_result_reader
// PURPOSE
//  Reader side of the FC1 output buffer: after FC1 finishes, fetches its N_OUT int8 class scores
//  from RAM_1 (base 0x8000) and streams them to the PS over an AXI-Stream-style master port.
//  Prefetches through a small FIFO to hide the RAM read latency and to absorb PS backpressure.
//  Optionally computes the argmax class index. Start/done handshake matches the other layer blocks.
// PARAMETERS
//  N_OUT       12       number of int8 results to read (1..16)
//  BASE_ADDR   16'h8000 RAM address of result 0; result k at BASE_ADDR+k
//  RD_LAT      2        RAM cycles from ram_en_r/ram_addr_r to valid ram_data_r (1..4)
//  FIFO_DEPTH  4        prefetch FIFO entries (power of 2, >= RD_LAT)
//  DONE_HOLD   4        cycles the done output stays high
// PORTS
//  clk         in   1   clock
//  rst_n       in   1   asynchronous, active-low reset
//  start       in   1   1-cycle pulse; accepted only in IDLE
//  busy        out  1   high from start acceptance until done drops
//  done        out  1   high for DONE_HOLD cycles after the last beat is accepted
//  ram_en_r    out  1   RAM read enable; high only in issue cycles
//  ram_addr_r  out  16  RAM read address
//  ram_data_r  in   8   RAM read data, signed int8, valid RD_LAT cycles after issue
//  m_tdata     out  8   result byte (signed)
//  m_tvalid    out  1   m_tdata valid
//  m_tready    in   1   sink ready
//  m_tlast     out  1   high with the beat of result N_OUT-1
//  class_idx   out  4   argmax index (FC_READER_ARGMAX_EN only, otherwise 0)
//  class_val   out  8   argmax score, signed (FC_READER_ARGMAX_EN only, otherwise 0)
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; state IDLE; issue, capture and pop counters 0.
//  FSM: IDLE -(start)-> FETCH -(issue_cnt==N_OUT)-> DRAIN -(last pop)-> DONE -(hold==DONE_HOLD-1)-> IDLE.
//   Entering DRAIN and popping the last beat in the same cycle goes straight to DONE.
//  Issue rule (FETCH): issue when inflight+fifo_count < FIFO_DEPTH; ram_en_r=1,
//   ram_addr_r=BASE_ADDR+issue_cnt, issue_cnt++. In-flight tracking uses an RD_LAT-deep valid shift register.
//  Capture: a shift-register bit exiting the pipe pushes ram_data_r into the FIFO. Credits guarantee no overflow.
//  Stream: m_tvalid = !fifo_empty; pop on m_tvalid&&m_tready; m_tdata/m_tvalid/m_tlast stay stable while
//   stalled. m_tlast = (pop_cnt==N_OUT-1). Push and pop in the same cycle: count unchanged.
//  m_tready low indefinitely: at most FIFO_DEPTH reads outstanding+buffered, then issue stalls; no data loss.
//  done: set the cycle after the last beat is accepted; held DONE_HOLD cycles; busy drops with done.
//  start while busy or done: ignored, with no effect on counters.
//  Async reset mid-operation: everything returns to reset values at once; in-flight RAM data is dropped.
// CONFIGURATION
//  `FC_READER_ARGMAX_EN defined: on each FIFO push, compare the pushed value (signed) against the running max.
//   Update when strictly greater, so ties keep the lowest index. The first push always loads.
//   class_idx/class_val are registered and final before done rises; they hold until the next accepted start,
//   which clears them to 0.
//  Undefined: no comparator logic; class_idx and class_val are tied to 0.
// STRUCTURE
//  Shared package (fc_pkg): RESULT_BASE_ADDR=16'h8000, FC1_N_OUT=12, RAM_RD_LAT=2, DONE_HOLD_CYC=4,
//   typedef logic signed [7:0] q8_t, FSM state enum {IDLE,FETCH,DRAIN,DONE}.
//  One sub-module: sync_fifo (parameters W, DEPTH; ports push/pop/din/dout/empty/full/count). First-word
//   fall-through, so dout is valid whenever !empty.
// TESTING
//  1 m_tready=1, RAM[0x8000..0x800B]={-5,3,7,-128,0,100,99,12,100,-1,2,-3}, start -> 12 beats in order,
//    tlast on beat 12, done high 4 cycles, class_idx=5 and class_val=100 (tie resolved to lower index).
//  2 m_tready=0 for 20 cycles after start -> exactly 4 ram_en_r pulses (0x8000..0x8003), m_tdata=-5 held;
//    after release, all 12 beats arrive with no loss or duplicates.
//  3 m_tready toggling 1/0 every cycle -> 12 beats in order; ram_addr_r never exceeds 0x800B.
//  4 start pulsed during FETCH and during done -> ignored; one 12-beat stream only.
//  5 rst_n low during beat 6 -> all outputs 0 asynchronously; the next start streams from 0x8000 again.
//  6 all results = -128 -> class_idx=0, class_val=-128; with macro undefined -> class_idx=0, class_val=0.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared FC-layer definitions: result buffer location, FC1 geometry, RAM timing,
// the int8 score type and the reader FSM state encoding.
package fc_pkg;

   localparam logic [15:0] RESULT_BASE_ADDR = 16'h8000;
   localparam int          FC1_N_OUT        = 12;
   localparam int          RAM_RD_LAT       = 2;
   localparam int          DONE_HOLD_CYC    = 4;

   typedef logic signed [7:0] q8_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } fc_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small first-word-fall-through FIFO: dout shows the oldest entry whenever !empty.
// Push is ignored when full and pop is ignored when empty.
module sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rptr];

   // Storage carries no reset; consumers only look at dout while !empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + AW'(1);
         if (do_pop)  rptr <= rptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fc_result_reader.sv
// Streams the FC1 int8 class scores from RAM to the PS through a prefetch FIFO.
// Define FC_READER_ARGMAX_EN to also track the argmax class index and score.
//
//  state | meaning
//  IDLE  | waiting for start
//  FETCH | issuing RAM reads while credits allow, streaming what has arrived
//  DRAIN | all reads issued, streaming the remaining buffered results
//  DONE  | last beat accepted, done held for DONE_HOLD cycles
module fc_result_reader
   import fc_pkg::*;
#(
   parameter int          N_OUT      = FC1_N_OUT,
   parameter logic [15:0] BASE_ADDR  = RESULT_BASE_ADDR,
   parameter int          RD_LAT     = RAM_RD_LAT,
   parameter int          FIFO_DEPTH = 4,
   parameter int          DONE_HOLD  = DONE_HOLD_CYC
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        ram_en_r,
   output logic [15:0] ram_addr_r,
   input  q8_t         ram_data_r,
   output q8_t         m_tdata,
   output logic        m_tvalid,
   input  logic        m_tready,
   output logic        m_tlast,
   output logic [3:0]  class_idx,
   output q8_t         class_val
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int HW = $clog2(DONE_HOLD) + 1;

   fc_state_t         state;
   logic [4:0]        issue_cnt;
   logic [4:0]        pop_cnt;
   logic [HW-1:0]     hold_cnt;
   logic [RD_LAT-1:0] vld_pipe;
   logic              cap;
   q8_t               fifo_dout;
   logic              fifo_empty;
   logic              fifo_full;
   logic [CW-1:0]     fifo_count;
   logic              pop;
   logic              last_pop;
   logic              issue;
   int                outstanding;

   sync_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (cap),
      .pop   (pop),
      .din   (ram_data_r),
      .dout  (fifo_dout),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (fifo_count)
   );

   // A read occupies a credit from its enable cycle until it leaves the FIFO.
   assign cap      = vld_pipe[RD_LAT-1];
   assign m_tvalid = !fifo_empty;
   assign m_tdata  = fifo_empty ? '0 : fifo_dout;
   assign m_tlast  = m_tvalid && (pop_cnt == 5'(N_OUT-1));
   assign pop      = m_tvalid && m_tready;
   assign last_pop = pop && (pop_cnt == 5'(N_OUT-1));

   always_comb begin
      outstanding = int'(ram_en_r) + $countones(vld_pipe) + int'(fifo_count);
      issue = (state == FETCH) && (issue_cnt < 5'(N_OUT)) && !fifo_full &&
              (outstanding < FIFO_DEPTH);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         ram_en_r   <= 1'b0;
         ram_addr_r <= '0;
         issue_cnt  <= '0;
         pop_cnt    <= '0;
         hold_cnt   <= '0;
         vld_pipe   <= '0;
      end else begin
         ram_en_r <= issue;
         vld_pipe <= (vld_pipe << 1) | RD_LAT'(ram_en_r);
         if (issue) begin
            ram_addr_r <= BASE_ADDR + 16'(issue_cnt);
            issue_cnt  <= issue_cnt + 5'd1;
         end
         if (pop) pop_cnt <= pop_cnt + 5'd1;

         case (state)
            IDLE: begin
               if (start) begin
                  state     <= FETCH;
                  busy      <= 1'b1;
                  issue_cnt <= '0;
                  pop_cnt   <= '0;
               end
            end
            FETCH: begin
               if (issue_cnt == 5'(N_OUT)) begin
                  if (last_pop) begin
                     state    <= DONE;
                     done     <= 1'b1;
                     hold_cnt <= '0;
                  end else begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (last_pop) begin
                  state    <= DONE;
                  done     <= 1'b1;
                  hold_cnt <= '0;
               end
            end
            DONE: begin
               if (hold_cnt == HW'(DONE_HOLD-1)) begin
                  state <= IDLE;
                  done  <= 1'b0;
                  busy  <= 1'b0;
               end else begin
                  hold_cnt <= hold_cnt + HW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef FC_READER_ARGMAX_EN
   logic [4:0] cap_cnt;
   logic [3:0] idx_q;
   q8_t        val_q;

   // Strictly-greater update keeps the lowest index on ties; first capture always loads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_cnt <= '0;
         idx_q   <= '0;
         val_q   <= '0;
      end else if (state == IDLE && start) begin
         cap_cnt <= '0;
         idx_q   <= '0;
         val_q   <= '0;
      end else if (cap) begin
         cap_cnt <= cap_cnt + 5'd1;
         if (cap_cnt == '0 || ram_data_r > val_q) begin
            idx_q <= cap_cnt[3:0];
            val_q <= ram_data_r;
         end
      end
   end

   assign class_idx = idx_q;
   assign class_val = val_q;
`else
   assign class_idx = '0;
   assign class_val = '0;
`endif

endmodule

// File: tb/tb_fc_result_reader.sv
// Directed bench for fc_result_reader: RAM model with 2-cycle read latency,
// stream monitor, and immediate-assertion checks against hand-computed results.
module tb_fc_result_reader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        busy, done, ram_en_r, m_tvalid, m_tready, m_tlast;
   logic [15:0] ram_addr_r;
   logic [7:0]  ram_q, d1;
   logic [7:0]  m_tdata;
   logic [3:0]  class_idx;
   logic [7:0]  class_val;

   int checks = 0;
   int errors = 0;

   logic [7:0]  ram [16];
   logic [7:0]  exp_data [12];
   logic [7:0]  beats [$];
   logic [15:0] addrs [$];
   logic [15:0] max_addr;
   int          tlast_pos, tlast_cnt, done_cyc;

   fc_result_reader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .ram_en_r   (ram_en_r),
      .ram_addr_r (ram_addr_r),
      .ram_data_r (ram_q),
      .m_tdata    (m_tdata),
      .m_tvalid   (m_tvalid),
      .m_tready   (m_tready),
      .m_tlast    (m_tlast),
      .class_idx  (class_idx),
      .class_val  (class_val)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      d1    <= (ram_en_r && ram_addr_r >= 16'h8000 && ram_addr_r < 16'h8010) ?
               ram[ram_addr_r[3:0]] : 8'h00;
      ram_q <= d1;
   end

   always @(posedge clk) begin
      if (m_tvalid && m_tready) begin
         beats.push_back(m_tdata);
         if (m_tlast) begin
            tlast_pos = beats.size();
            tlast_cnt++;
         end
      end
      if (ram_en_r) begin
         addrs.push_back(ram_addr_r);
         if (ram_addr_r > max_addr) max_addr = ram_addr_r;
      end
      if (done) done_cyc++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      beats.delete();
      addrs.delete();
      max_addr  = '0;
      tlast_pos = 0;
      tlast_cnt = 0;
      done_cyc  = 0;
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input bit toggle);
      int n = 0;
      while ((busy || done) && n < budget) begin
         if (toggle) m_tready = ~m_tready;
         @(negedge clk);
         n++;
      end
      m_tready = 1'b1;
      chk("idle_timeout", 32'(busy | done), 32'd0);
   endtask

   task automatic check_stream(input string tag);
      chk({tag, "_nbeats"}, 32'(beats.size()), 32'd12);
      for (int i = 0; i < 12 && i < beats.size(); i++)
         chk({tag, "_beat"}, 32'(beats[i]), 32'(exp_data[i]));
      chk({tag, "_tlast_pos"}, 32'(tlast_pos), 32'd12);
      chk({tag, "_tlast_cnt"}, 32'(tlast_cnt), 32'd1);
   endtask

   task automatic load_ram(input logic [7:0] fill, input bit use_exp);
      for (int i = 0; i < 16; i++) ram[i] = 8'h00;
      for (int i = 0; i < 12; i++) ram[i] = use_exp ? exp_data[i] : fill;
   endtask

   initial begin
      exp_data = '{8'hFB, 8'h03, 8'h07, 8'h80, 8'h00, 8'h64,
                   8'h63, 8'h0C, 8'h64, 8'hFF, 8'h02, 8'hFD};
      m_tready = 1'b1;
      load_ram(8'h00, 1'b1);
      clr();

      // reset state
      tick(3);
      chk("rst_busy",   32'(busy), 32'd0);
      chk("rst_done",   32'(done), 32'd0);
      chk("rst_ram_en", 32'(ram_en_r), 32'd0);
      chk("rst_addr",   32'(ram_addr_r), 32'd0);
      chk("rst_tvalid", 32'(m_tvalid), 32'd0);
      chk("rst_tdata",  32'(m_tdata), 32'd0);
      chk("rst_tlast",  32'(m_tlast), 32'd0);
      chk("rst_cidx",   32'(class_idx), 32'd0);
      chk("rst_cval",   32'(class_val), 32'd0);
      rst_n = 1'b1;
      tick(2);

      // 1: free-flowing stream
      clr();
      pulse_start();
      chk("t1_busy", 32'(busy), 32'd1);
      wait_idle(300, 1'b0);
      check_stream("t1");
      chk("t1_done_cyc", 32'(done_cyc), 32'd4);
      chk("t1_naddr", 32'(addrs.size()), 32'd12);
      chk("t1_first_addr", 32'(addrs.size() > 0 ? addrs[0] : 16'hxxxx), 32'h8000);
`ifdef FC_READER_ARGMAX_EN
      chk("t1_cidx", 32'(class_idx), 32'd5);
      chk("t1_cval", 32'(class_val), 32'h64);
`else
      chk("t1_cidx", 32'(class_idx), 32'd0);
      chk("t1_cval", 32'(class_val), 32'd0);
`endif

      // 2: sink stalled for 20 cycles
      clr();
      m_tready = 1'b0;
      pulse_start();
      tick(6);
      chk("t2_tdata_early", 32'(m_tdata), 32'hFB);
      tick(13);
      chk("t2_nreads", 32'(addrs.size()), 32'd4);
      for (int i = 0; i < 4 && i < addrs.size(); i++)
         chk("t2_addr", 32'(addrs[i]), 32'h8000 + 32'(i));
      chk("t2_tvalid", 32'(m_tvalid), 32'd1);
      chk("t2_tdata_held", 32'(m_tdata), 32'hFB);
      chk("t2_nbeats_stalled", 32'(beats.size()), 32'd0);
      m_tready = 1'b1;
      wait_idle(300, 1'b0);
      check_stream("t2");

      // 3: ready toggling every cycle
      clr();
      pulse_start();
      wait_idle(400, 1'b1);
      check_stream("t3");
      chk("t3_max_addr", 32'(max_addr), 32'h800B);

      // 4: start pulses while busy and while done
      clr();
      pulse_start();
      tick(3);
      pulse_start();
      begin
         int n = 0;
         while (!done && n < 300) begin
            @(negedge clk);
            n++;
         end
         chk("t4_done_seen", 32'(done), 32'd1);
      end
      pulse_start();
      wait_idle(50, 1'b0);
      tick(5);
      chk("t4_busy_after", 32'(busy), 32'd0);
      chk("t4_naddr", 32'(addrs.size()), 32'd12);
      check_stream("t4");

      // 5: async reset while beat 6 is on the bus
      clr();
      pulse_start();
      begin
         int n = 0;
         while (beats.size() < 5 && n < 300) begin
            @(negedge clk);
            n++;
         end
         chk("t5_reach_beat6", 32'(beats.size()), 32'd5);
      end
      #2 rst_n = 1'b0;
      #1;
      chk("t5_busy",   32'(busy), 32'd0);
      chk("t5_done",   32'(done), 32'd0);
      chk("t5_ram_en", 32'(ram_en_r), 32'd0);
      chk("t5_addr",   32'(ram_addr_r), 32'd0);
      chk("t5_tvalid", 32'(m_tvalid), 32'd0);
      chk("t5_tdata",  32'(m_tdata), 32'd0);
      chk("t5_cidx",   32'(class_idx), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick(2);
      clr();
      pulse_start();
      wait_idle(300, 1'b0);
      chk("t5_restart_addr", 32'(addrs.size() > 0 ? addrs[0] : 16'hxxxx), 32'h8000);
      check_stream("t5");

      // 6: all scores equal to the minimum
      load_ram(8'h80, 1'b0);
      for (int i = 0; i < 12; i++) exp_data[i] = 8'h80;
      clr();
      pulse_start();
      wait_idle(300, 1'b0);
      check_stream("t6");
`ifdef FC_READER_ARGMAX_EN
      chk("t6_cidx", 32'(class_idx), 32'd0);
      chk("t6_cval", 32'(class_val), 32'h80);
`else
      chk("t6_cidx", 32'(class_idx), 32'd0);
      chk("t6_cval", 32'(class_val), 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
